// File: rtl/gnn_pkg.sv
// Shared GNN pipeline constants and the dispatcher state encoding.
package gnn_pkg;

    localparam int unsigned TOTAL_F    = 3703;
    localparam int unsigned NUM_CORE   = 64;
    localparam int unsigned F_PER_CORE = 32;
    localparam int unsigned FW         = 12;
    localparam int unsigned EW         = 16;
    localparam int unsigned CW         = $clog2(NUM_CORE);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDGE_A = 2'd1,
        ST_EDGE_B = 2'd2,
        ST_CARRY  = 2'd3
    } disp_state_e;

endpackage

// File: rtl/range_chunker.sv
// One work chunk: hi = min(lo+32, end, cap), done when hi reaches min(end, cap).
module range_chunker
    import gnn_pkg::*;
(
    input  logic [FW-1:0] lo_i,
    input  logic [FW-1:0] end_i,
    input  logic [FW-1:0] cap_i,
    output logic [FW-1:0] hi_o,
    output logic          done_o
);

    logic [FW:0] step;
    logic [FW:0] lim;
    logic [FW:0] hi_w;

    // Chunk end and completion flag, evaluated one bit wider so lo+32 cannot wrap.
    always_comb begin
        step   = {1'b0, lo_i} + (FW+1)'(F_PER_CORE);
        lim    = (end_i < cap_i) ? {1'b0, end_i} : {1'b0, cap_i};
        hi_w   = (step < lim) ? step : lim;
        hi_o   = FW'(hi_w);
        done_o = (hi_w == lim);
    end

endmodule

// File: rtl/s2_core_dispatch.sv
// Walks the compute cores for one S2 split: edge e_i tail, then edge e_i+1 head,
// emitting a carry-over start feature when the cores run out first.
module s2_core_dispatch
    import gnn_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          split_valid,
    output logic          split_ready,
    input  logic [FW-1:0] last_f,
    input  logic [FW-1:0] f21,
    input  logic [FW-1:0] f22,
    input  logic          need_mt64,
    input  logic [EW-1:0] edge_idx,
    output logic          asg_valid,
    input  logic          asg_ready,
    output logic [CW-1:0] asg_core,
    output logic [EW-1:0] asg_edge,
    output logic [FW-1:0] asg_f_lo,
    output logic [FW-1:0] asg_f_hi,
    output logic          asg_last,
    output logic          fin_valid,
    input  logic          fin_ready,
    output logic [FW-1:0] fin,
    output logic [EW-1:0] fin_edge,
    output logic          fin_mt64
);

    localparam logic [CW-1:0] CORE_MAX   = CW'(NUM_CORE - 1);
    localparam logic [FW-1:0] TOTAL_FW   = FW'(TOTAL_F);

    disp_state_e   state_q, state_d;
    logic [CW-1:0] core_q, core_d;
    logic [FW-1:0] lo_q, lo_d;
    logic [FW-1:0] hi_q, hi_d;
    logic          done_q, done_d;
    logic          last_q, last_d;
    logic [FW-1:0] f21_q, f21_d;
    logic [FW-1:0] f22_q, f22_d;
    logic          mt64_q, mt64_d;
    logic [EW-1:0] edge_q, edge_d;
    logic [EW-1:0] asg_edge_q, asg_edge_d;
    logic [FW-1:0] fin_q, fin_d;
    logic [EW-1:0] fin_edge_q, fin_edge_d;

    logic          load_chunk;
    logic          asg_hs;
    logic [FW-1:0] chunk_end;
    logic [FW-1:0] chunk_cap;
    logic [FW-1:0] chunk_hi;
    logic          chunk_done;

    assign split_ready = (state_q == ST_IDLE);
    assign asg_valid   = (state_q == ST_EDGE_A) || (state_q == ST_EDGE_B);
    assign fin_valid   = (state_q == ST_CARRY);
    assign asg_core    = core_q;
    assign asg_edge    = asg_edge_q;
    assign asg_f_lo    = lo_q;
    assign asg_f_hi    = hi_q;
    assign asg_last    = last_q;
    assign fin         = fin_q;
    assign fin_edge    = fin_edge_q;
    assign fin_mt64    = mt64_q;
    assign asg_hs      = asg_valid && asg_ready;

    // State and datapath registers; reset drops any round in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            core_q     <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            done_q     <= 1'b0;
            last_q     <= 1'b0;
            f21_q      <= '0;
            f22_q      <= '0;
            mt64_q     <= 1'b0;
            edge_q     <= '0;
            asg_edge_q <= '0;
            fin_q      <= '0;
            fin_edge_q <= '0;
        end else begin
            state_q    <= state_d;
            core_q     <= core_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            done_q     <= done_d;
            last_q     <= last_d;
            f21_q      <= f21_d;
            f22_q      <= f22_d;
            mt64_q     <= mt64_d;
            edge_q     <= edge_d;
            asg_edge_q <= asg_edge_d;
            fin_q      <= fin_d;
            fin_edge_q <= fin_edge_d;
        end
    end

    // Next-state: split accept, per-handshake core walk and carry resolution.
    always_comb begin
        state_d    = state_q;
        core_d     = core_q;
        lo_d       = lo_q;
        f21_d      = f21_q;
        f22_d      = f22_q;
        mt64_d     = mt64_q;
        edge_d     = edge_q;
        fin_d      = fin_q;
        fin_edge_d = fin_edge_q;
        load_chunk = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (split_valid) begin
                    f21_d  = f21;
                    f22_d  = f22;
                    mt64_d = need_mt64;
                    edge_d = edge_idx;
                    core_d = '0;
                    if (last_f < f21) begin
                        state_d    = ST_EDGE_A;
                        lo_d       = last_f;
                        load_chunk = 1'b1;
                    end else if (f22 != '0) begin
                        state_d    = ST_EDGE_B;
                        lo_d       = '0;
                        load_chunk = 1'b1;
                    end
                end
            end
            ST_EDGE_A: begin
                if (asg_hs) begin
                    if (done_q) begin
                        if ((core_q != CORE_MAX) && (f22_q != '0)) begin
                            state_d    = ST_EDGE_B;
                            core_d     = core_q + CW'(1);
                            lo_d       = '0;
                            load_chunk = 1'b1;
                        end else begin
                            // Edge e_i+1 never started: its carry begins at feature 0.
                            state_d    = ST_CARRY;
                            fin_d      = '0;
                            fin_edge_d = edge_q + EW'(1);
                        end
                    end else if (core_q == CORE_MAX) begin
                        state_d    = ST_CARRY;
                        fin_d      = hi_q;
                        fin_edge_d = edge_q;
                    end else begin
                        core_d     = core_q + CW'(1);
                        lo_d       = hi_q;
                        load_chunk = 1'b1;
                    end
                end
            end
            ST_EDGE_B: begin
                if (asg_hs) begin
                    if (done_q || (core_q == CORE_MAX)) begin
                        if (hi_q < TOTAL_FW) begin
                            state_d    = ST_CARRY;
                            fin_d      = hi_q;
                            fin_edge_d = edge_q + EW'(1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        core_d     = core_q + CW'(1);
                        lo_d       = hi_q;
                        load_chunk = 1'b1;
                    end
                end
            end
            ST_CARRY: begin
                if (fin_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Range limits for the chunk about to be presented.
    always_comb begin
        chunk_end = f22_d;
        chunk_cap = TOTAL_FW;
        if (state_d == ST_EDGE_A) begin
            chunk_end = f21_d;
            chunk_cap = f21_d;
        end
    end

    range_chunker u_chunker (
        .lo_i   (lo_d),
        .end_i  (chunk_end),
        .cap_i  (chunk_cap),
        .hi_o   (chunk_hi),
        .done_o (chunk_done)
    );

    // Precompute hi, done, last and edge of the next assignment so they leave a flop.
    always_comb begin
        hi_d       = hi_q;
        done_d     = done_q;
        last_d     = last_q;
        asg_edge_d = asg_edge_q;
        if (load_chunk) begin
            hi_d   = chunk_hi;
            done_d = chunk_done;
            if (state_d == ST_EDGE_A) begin
                last_d     = (chunk_done && !((core_d != CORE_MAX) && (f22_d != '0)))
                             || (core_d == CORE_MAX);
                asg_edge_d = edge_d;
            end else begin
                last_d     = chunk_done || (core_d == CORE_MAX);
                asg_edge_d = edge_d + EW'(1);
            end
        end
    end

endmodule
